// File: rtl/mask_count_if.sv
// Handshake bundle between a word producer, the mask count decoder and the result consumer.
//
// Valid/ready semantics on both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds valid and its
// payload stable until that edge. The consumer side may raise or lower ready
// freely.
interface mask_count_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       B;
   logic             all_zero;

   // Decoder side: takes words in and presents results.
   modport slave (
      input  in_valid, A, out_ready,
      output in_ready, out_valid, B, all_zero
   );

   // Producer/consumer side: the block that drives the decoder.
   modport master (
      output in_valid, A, out_ready,
      input  in_ready, out_valid, B, all_zero
   );
endinterface

// File: rtl/mask_count_decoder.sv
// Iterative trailing-zero decoder. It scans a WIDTH-bit word one DIGIT-wide
// digit per cycle. It reports the mask count B, which is the largest B such
// that clearing the low B bits leaves the word unchanged. all_zero flags the
// case where the word is zero and B equals WIDTH.
module mask_count_decoder #(
   parameter int WIDTH = 64,
   parameter int DIGIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   mask_count_if.slave bus,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [7:0] DIGIT8 = 8'(DIGIT);
   localparam logic [7:0] WIDTH8 = 8'(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [7:0]       cnt;
   logic             in_ready;
   logic             out_valid;
   logic [7:0]       b_q;
   logic             all_zero;
   logic [DIGIT-1:0] digit;
   logic [7:0]       digit_idx;

   // Index of the lowest set bit in a digit. The result is 0 when the digit is zero.
   function automatic logic [7:0] low_index(input logic [DIGIT-1:0] d);
      logic [7:0] idx;
      idx = 8'd0;
      for (int i = DIGIT - 1; i >= 0; i--) begin
         if (d[i]) idx = 8'(i);
      end
      return idx;
   endfunction

   // Look at the current low digit of the shift register.
   always_comb begin
      digit     = sr[DIGIT-1:0];
      digit_idx = low_index(sr[DIGIT-1:0]);
   end

   // Control FSM and datapath. All outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         b_q       <= 8'h00;
         all_zero  <= 1'b0;
         cnt       <= 8'h00;
         sr        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sr       <= bus.A;
                  cnt      <= 8'h00;
                  in_ready <= 1'b0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (|digit) begin
                  b_q       <= cnt + digit_idx;
                  all_zero  <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else if (cnt + DIGIT8 == WIDTH8) begin
                  // Last digit is also zero, so the whole word is zero.
                  b_q       <= WIDTH8;
                  all_zero  <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt + DIGIT8;
                  sr  <= sr >> DIGIT;
               end
            end
            HOLD: begin
               // Return to IDLE only. A new word is accepted no earlier than the next cycle.
               if (bus.out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.B         = b_q;
   assign bus.all_zero  = all_zero;
   assign state_dbg     = state;

endmodule

// File: tb/tb_mask_count_decoder.sv
// Directed and random stimulus for mask_count_decoder. A reference
// trailing-zero counter and the masking contract produce the expected results.
module tb_mask_count_decoder;
   localparam int WIDTH = 64;
   localparam int DIGIT = 4;

   // Clock and reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mask_count_if #(.WIDTH(WIDTH)) bus ();
   logic [1:0] state_dbg;

   mask_count_decoder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   int passed = 0;
   int total  = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // Reference model: count zero bits from the LSB up.
   function automatic int ref_tz(input logic [WIDTH-1:0] a);
      int n;
      n = 0;
      while (n < WIDTH && a[n] == 1'b0) n++;
      return n;
   endfunction

   function automatic int ref_latency(input int tz);
      if (tz >= WIDTH) return WIDTH / DIGIT;
      return tz / DIGIT + 1;
   endfunction

   // Driver: offer one word, wait for the result, check it, then hold for a while and release.
   task automatic decode(input logic [WIDTH-1:0] a, input int hold, input bit toggle);
      int tz;
      int lat;
      logic [7:0] b_seen;
      logic [WIDTH-1:0] m;
      tz = ref_tz(a);
      exp_q.push_back(8'(tz));
      check("in_ready_idle", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.A        = a;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.A        = {$urandom(), $urandom()};
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 64'(lat), 64'(ref_latency(tz)));
      check("B", 64'(bus.B), 64'(exp_q.pop_front()));
      check("all_zero", 64'(bus.all_zero), 64'(a == '0));
      b_seen = bus.B;
      m = (a >> b_seen) << b_seen;
      check("mask_keep", m, a);
      if (!bus.all_zero) begin
         m = (a >> (b_seen + 8'd1)) << (b_seen + 8'd1);
         check("mask_tight", 64'(m != a), 64'd1);
      end
      for (int i = 0; i < hold; i++) begin
         if (toggle) begin
            bus.in_valid = 1'b1;
            bus.A        = {$urandom(), $urandom()};
         end
         @(posedge clk); #1;
         check("hold_valid", 64'(bus.out_valid), 64'd1);
         check("hold_B", 64'(bus.B), 64'(b_seen));
         check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("release_in_ready", 64'(bus.in_ready), 64'd1);
      check("release_out_valid", 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] a;
      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_B", 64'(bus.B), 64'h00);
      check("rst_all_zero", 64'(bus.all_zero), 64'd0);

      // Directed corner cases
      decode(64'h0000_0000_0000_0001, 0, 1'b0);
      decode(64'h0000_0000_0000_00F0, 0, 1'b0);
      decode(64'h0000_0000_0000_0008, 0, 1'b0);
      decode(64'h8000_0000_0000_0000, 0, 1'b0);
      decode(64'h0000_0000_0000_0000, 0, 1'b0);

      // Backpressure while the producer toggles in_valid and A
      decode(64'h0000_0000_0012_3400, 5, 1'b1);
      decode(64'h0000_0000_0000_0100, 0, 1'b0);

      // Reset in the middle of a scan
      check("pre_scan_in_ready", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.A        = 64'h1000_0000_0000_0000;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_scan_out_valid", 64'(bus.out_valid), 64'd0);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_B", 64'(bus.B), 64'h00);
      check("abort_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      decode(64'h0000_0000_0001_0000, 0, 1'b0);

      // Random regression with random backpressure
      for (int n = 0; n < 1000; n++) begin
         a = {$urandom(), $urandom()};
         a = a << $urandom_range(0, WIDTH);
         if ($urandom_range(0, 31) == 0) a = '0;
         decode(a, $urandom_range(0, 3), 1'(($urandom_range(0, 1))));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
